// File: rtl/riscv_v_result_pipe.sv
// Result-side MEM/WB pipeline of the vector unit: feeds the vector RF write port,
// the MEM/WB bypass taps, the decode pending-write scoreboard and a retire counter.
module riscv_v_result_pipe #(
   parameter int DATA_W    = 128,
   parameter int XLEN      = 32,
   parameter int NUM_BYTES = DATA_W / 8,
   parameter int ADDR_W    = 5,
   parameter int CNT_W     = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     valid_exe,
   input  logic                     flush_exe,
   input  logic                     stall_mem,
   input  logic                     is_v2i_exe,
   input  logic [ADDR_W-1:0]        rd_addr_exe,
   input  logic [NUM_BYTES-1:0]     wr_en_exe,
   input  logic [DATA_W-1:0]        result_exe,
   input  logic [XLEN-1:0]          int_result_exe,
   output logic [NUM_BYTES-1:0]     rf_wr_en_mem,
   output logic [ADDR_W-1:0]        rf_wr_addr_mem,
   output logic [DATA_W-1:0]        rf_wr_data_mem,
   output logic [NUM_BYTES-1:0]     rf_wr_en_wb,
   output logic [ADDR_W-1:0]        rf_wr_addr_wb,
   output logic [DATA_W-1:0]        rf_wr_data_wb,
   output logic                     int_wr_valid_wb,
   output logic [XLEN-1:0]          int_wr_data_wb,
   output logic [(1<<ADDR_W)-1:0]   busy_vreg,
   output logic [CNT_W-1:0]         retire_cnt
);

   localparam int NUM_REGS = 1 << ADDR_W;

   logic                 memValid_q, memValid_d;
   logic                 memV2i_q,   memV2i_d;
   logic [ADDR_W-1:0]    memAddr_q,  memAddr_d;
   logic [NUM_BYTES-1:0] memEn_q,    memEn_d;
   logic [DATA_W-1:0]    memData_q,  memData_d;
   logic [XLEN-1:0]      memInt_q,   memInt_d;

   logic                 wbValid_q, wbValid_d;
   logic                 wbV2i_q,   wbV2i_d;
   logic [ADDR_W-1:0]    wbAddr_q,  wbAddr_d;
   logic [NUM_BYTES-1:0] wbEn_q,    wbEn_d;
   logic [DATA_W-1:0]    wbData_q,  wbData_d;
   logic [XLEN-1:0]      wbInt_q,   wbInt_d;

   logic [CNT_W-1:0]     retireCnt_q, retireCnt_d;

   // A stalled MEM holds everything; WB then takes a bubble so the held op is not written twice.
   always_comb begin
      memValid_d = memValid_q;
      memV2i_d   = memV2i_q;
      memAddr_d  = memAddr_q;
      memEn_d    = memEn_q;
      memData_d  = memData_q;
      memInt_d   = memInt_q;
      if (!stall_mem) begin
         memValid_d = valid_exe & ~flush_exe;
         memV2i_d   = is_v2i_exe;
         memAddr_d  = rd_addr_exe;
         memEn_d    = (memValid_d & ~is_v2i_exe) ? wr_en_exe : '0;
         memData_d  = result_exe;
         memInt_d   = int_result_exe;
      end
      wbValid_d = stall_mem ? 1'b0 : memValid_q;
      wbEn_d    = stall_mem ? '0   : memEn_q;
      wbV2i_d   = memV2i_q;
      wbAddr_d  = memAddr_q;
      wbData_d  = memData_q;
      wbInt_d   = memInt_q;
      retireCnt_d = wbValid_q ? retireCnt_q + CNT_W'(1) : retireCnt_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         memValid_q  <= 1'b0;
         memV2i_q    <= 1'b0;
         memAddr_q   <= '0;
         memEn_q     <= '0;
         memData_q   <= '0;
         memInt_q    <= '0;
         wbValid_q   <= 1'b0;
         wbV2i_q     <= 1'b0;
         wbAddr_q    <= '0;
         wbEn_q      <= '0;
         wbData_q    <= '0;
         wbInt_q     <= '0;
         retireCnt_q <= '0;
      end else begin
         memValid_q  <= memValid_d;
         memV2i_q    <= memV2i_d;
         memAddr_q   <= memAddr_d;
         memEn_q     <= memEn_d;
         memData_q   <= memData_d;
         memInt_q    <= memInt_d;
         wbValid_q   <= wbValid_d;
         wbV2i_q     <= wbV2i_d;
         wbAddr_q    <= wbAddr_d;
         wbEn_q      <= wbEn_d;
         wbData_q    <= wbData_d;
         wbInt_q     <= wbInt_d;
         retireCnt_q <= retireCnt_d;
      end
   end

   // Only ops that will really write a vector register mark it busy.
   always_comb begin
      busy_vreg = '0;
      for (int r = 0; r < NUM_REGS; r++) begin
         if ((memValid_q && !memV2i_q && (memEn_q != '0) && (memAddr_q == ADDR_W'(r))) ||
             (wbValid_q  && !wbV2i_q  && (wbEn_q  != '0) && (wbAddr_q  == ADDR_W'(r))))
            busy_vreg[r] = 1'b1;
      end
   end

   assign rf_wr_en_mem    = memValid_q ? memEn_q : '0;
   assign rf_wr_addr_mem  = memAddr_q;
   assign rf_wr_data_mem  = memData_q;
   assign rf_wr_en_wb     = wbValid_q ? wbEn_q : '0;
   assign rf_wr_addr_wb   = wbAddr_q;
   assign rf_wr_data_wb   = wbData_q;
   assign int_wr_valid_wb = wbValid_q & wbV2i_q;
   assign int_wr_data_wb  = wbInt_q;
   assign retire_cnt      = retireCnt_q;

endmodule

// File: tb/tb_riscv_v_result_pipe.sv
// Scoreboard bench for riscv_v_result_pipe: every captured op that should write back is
// queued at issue time and matched against the WB outputs when it arrives there.
module tb_riscv_v_result_pipe;

   logic          clk;
   logic          rst;
   logic          valid_exe;
   logic          flush_exe;
   logic          stall_mem;
   logic          is_v2i_exe;
   logic [4:0]    rd_addr_exe;
   logic [15:0]   wr_en_exe;
   logic [127:0]  result_exe;
   logic [31:0]   int_result_exe;
   logic [15:0]   rf_wr_en_mem;
   logic [4:0]    rf_wr_addr_mem;
   logic [127:0]  rf_wr_data_mem;
   logic [15:0]   rf_wr_en_wb;
   logic [4:0]    rf_wr_addr_wb;
   logic [127:0]  rf_wr_data_wb;
   logic          int_wr_valid_wb;
   logic [31:0]   int_wr_data_wb;
   logic [31:0]   busy_vreg;
   logic [15:0]   retire_cnt;

   typedef struct packed {
      logic         v2i;
      logic [4:0]   addr;
      logic [15:0]  en;
      logic [127:0] data;
      logic [31:0]  intData;
   } wbExp_t;

   wbExp_t      expQ[$];
   int          testsRun;
   int          testsFailed;
   logic [15:0] expRetire;

   riscv_v_result_pipe dut (
      .clk             (clk),
      .rst             (rst),
      .valid_exe       (valid_exe),
      .flush_exe       (flush_exe),
      .stall_mem       (stall_mem),
      .is_v2i_exe      (is_v2i_exe),
      .rd_addr_exe     (rd_addr_exe),
      .wr_en_exe       (wr_en_exe),
      .result_exe      (result_exe),
      .int_result_exe  (int_result_exe),
      .rf_wr_en_mem    (rf_wr_en_mem),
      .rf_wr_addr_mem  (rf_wr_addr_mem),
      .rf_wr_data_mem  (rf_wr_data_mem),
      .rf_wr_en_wb     (rf_wr_en_wb),
      .rf_wr_addr_wb   (rf_wr_addr_wb),
      .rf_wr_data_wb   (rf_wr_data_wb),
      .int_wr_valid_wb (int_wr_valid_wb),
      .int_wr_data_wb  (int_wr_data_wb),
      .busy_vreg       (busy_vreg),
      .retire_cnt      (retire_cnt)
   );

   // 10-unit clock period
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   // Drives one cycle of execute-stage inputs, queues the expected write-back, returns 1 unit after the edge.
   task automatic applyStimulus(input logic v, input logic f, input logic s, input logic i,
                                input logic [4:0] rd, input logic [15:0] en,
                                input logic [127:0] d, input logic [31:0] iv);
      wbExp_t e;
      valid_exe      = v;
      flush_exe      = f;
      stall_mem      = s;
      is_v2i_exe     = i;
      rd_addr_exe    = rd;
      wr_en_exe      = en;
      result_exe     = d;
      int_result_exe = iv;
      if (v && !f && !s) begin
         expRetire = expRetire + 16'd1;
         if (i || en != 16'h0) begin
            e.v2i     = i;
            e.addr    = rd;
            e.en      = i ? 16'h0 : en;
            e.data    = d;
            e.intData = iv;
            expQ.push_back(e);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 16'h0, 128'h0, 32'h0);
   endtask

   // Any write seen at WB must be the oldest outstanding queued op.
   always @(negedge clk) begin
      if (!rst && (rf_wr_en_wb != 16'h0 || int_wr_valid_wb)) begin
         if (expQ.size() == 0) begin
            checkOutput("wb_unexpected_write", {rf_wr_en_wb, int_wr_valid_wb}, 256'h0);
         end else begin
            wbExp_t e;
            e = expQ.pop_front();
            checkOutput("wb_en", rf_wr_en_wb, e.en);
            checkOutput("wb_int_valid", int_wr_valid_wb, e.v2i);
            if (e.v2i) begin
               checkOutput("wb_int_data", int_wr_data_wb, e.intData);
            end else begin
               checkOutput("wb_addr", rf_wr_addr_wb, e.addr);
               checkOutput("wb_data", rf_wr_data_wb, e.data);
            end
         end
      end
   end

   initial begin
      logic [127:0] a5;
      testsRun    = 0;
      testsFailed = 0;
      expRetire   = 16'd0;
      a5 = {16{8'hA5}};
      rst = 1'b1;
      valid_exe = 1'b0; flush_exe = 1'b0; stall_mem = 1'b0; is_v2i_exe = 1'b0;
      rd_addr_exe = 5'd0; wr_en_exe = 16'h0; result_exe = 128'h0; int_result_exe = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_en_mem", rf_wr_en_mem, 16'h0);
      checkOutput("reset_en_wb", rf_wr_en_wb, 16'h0);
      checkOutput("reset_busy", busy_vreg, 32'h0);
      checkOutput("reset_retire", retire_cnt, 16'h0);
      checkOutput("reset_int_valid", int_wr_valid_wb, 1'b0);
      rst = 1'b0;

      // Single op to v3
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 5'd3, 16'hFFFF, a5, 32'h0);
      checkOutput("single_mem_en", rf_wr_en_mem, 16'hFFFF);
      checkOutput("single_mem_addr", rf_wr_addr_mem, 5'd3);
      checkOutput("single_mem_data", rf_wr_data_mem, a5);
      checkOutput("single_busy_mem", busy_vreg, 32'h8);
      idle();
      checkOutput("single_wb_en", rf_wr_en_wb, 16'hFFFF);
      checkOutput("single_wb_data", rf_wr_data_wb, a5);
      checkOutput("single_mem_empty", rf_wr_en_mem, 16'h0);
      checkOutput("single_busy_wb", busy_vreg, 32'h8);
      idle();
      checkOutput("single_busy_clear", busy_vreg, 32'h0);
      checkOutput("single_retire", retire_cnt, 16'd1);

      // Back-to-back ops to v1 then v2
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 5'd1, 16'h00FF, 128'h1111, 32'h0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 5'd2, 16'h00FF, 128'h2222, 32'h0);
      checkOutput("b2b_mem_addr", rf_wr_addr_mem, 5'd2);
      checkOutput("b2b_wb_addr", rf_wr_addr_wb, 5'd1);
      checkOutput("b2b_mem_en", rf_wr_en_mem, 16'h00FF);
      checkOutput("b2b_busy", busy_vreg, 32'h6);
      idle();
      idle();
      checkOutput("b2b_retire", retire_cnt, expRetire);

      // Stall for two cycles with a flushed op waiting in execute
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 5'd4, 16'h0F0F, 128'h4444, 32'h0);
      checkOutput("stall_mem_addr0", rf_wr_addr_mem, 5'd4);
      for (int k = 0; k < 2; k++) begin
         applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 5'd9, 16'hFFFF, 128'h9999, 32'h0);
         checkOutput("stall_mem_addr", rf_wr_addr_mem, 5'd4);
         checkOutput("stall_mem_en", rf_wr_en_mem, 16'h0F0F);
         checkOutput("stall_wb_bubble", rf_wr_en_wb, 16'h0);
         checkOutput("stall_busy", busy_vreg, 32'h10);
      end
      idle();
      checkOutput("release_wb_addr", rf_wr_addr_wb, 5'd4);
      checkOutput("release_wb_en", rf_wr_en_wb, 16'h0F0F);
      checkOutput("release_mem_en", rf_wr_en_mem, 16'h0);
      idle();
      checkOutput("stall_retire", retire_cnt, expRetire);

      // Flush without stall is dropped before MEM
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 5'd12, 16'hFFFF, 128'hCC, 32'h0);
      checkOutput("flush_mem_en", rf_wr_en_mem, 16'h0);
      checkOutput("flush_busy", busy_vreg, 32'h0);
      idle();
      idle();

      // v2i op to x7
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 5'd7, 16'hFFFF, a5, 32'hDEADBEEF);
      checkOutput("v2i_mem_en", rf_wr_en_mem, 16'h0);
      checkOutput("v2i_busy_mem", busy_vreg, 32'h0);
      idle();
      checkOutput("v2i_int_valid", int_wr_valid_wb, 1'b1);
      checkOutput("v2i_int_data", int_wr_data_wb, 32'hDEADBEEF);
      checkOutput("v2i_wb_en", rf_wr_en_wb, 16'h0);
      checkOutput("v2i_busy_wb", busy_vreg, 32'h0);
      idle();
      checkOutput("v2i_int_valid_done", int_wr_valid_wb, 1'b0);

      // Valid op with no enables: retires, sets no busy bit
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 5'd5, 16'h0, 128'h55, 32'h0);
      checkOutput("zero_en_busy", busy_vreg, 32'h0);
      idle();
      idle();
      checkOutput("zero_en_retire", retire_cnt, expRetire);

      // Random traffic with stalls and flushes
      for (int n = 0; n < 40; n++) begin
         logic [15:0] en;
         en = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
         applyStimulus(1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0),
                       ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
                       5'($urandom), en, {$urandom, $urandom, $urandom, $urandom}, $urandom);
      end
      idle();
      idle();
      checkOutput("random_retire", retire_cnt, expRetire);
      checkOutput("random_queue_drained", expQ.size(), 0);

      // Asynchronous reset with MEM and WB occupied
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 5'd10, 16'hFFFF, 128'hA0, 32'h0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 5'd11, 16'hFFFF, 128'hB0, 32'h0);
      valid_exe = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      checkOutput("areset_mem_en", rf_wr_en_mem, 16'h0);
      checkOutput("areset_wb_en", rf_wr_en_wb, 16'h0);
      checkOutput("areset_busy", busy_vreg, 32'h0);
      checkOutput("areset_retire", retire_cnt, 16'h0);
      expQ.delete();
      expRetire = 16'd0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (3) idle();
      checkOutput("post_reset_retire", retire_cnt, 16'h0);

      // Counter wrap after 65535 retirements
      for (int n = 0; n < 65535; n++)
         applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 16'h0, 128'h0, 32'h0);
      idle();
      idle();
      checkOutput("wrap_preload", retire_cnt, 16'hFFFF);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 16'h0, 128'h0, 32'h0);
      idle();
      idle();
      checkOutput("wrap_zero", retire_cnt, 16'h0);
      checkOutput("wrap_model", retire_cnt, expRetire);
      checkOutput("final_queue_drained", expQ.size(), 0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/riscv_v_result_pipe.md
# riscv_v_result_pipe

Result-side pipeline of the RISC-V vector unit. It captures vector and vector-to-integer results leaving the execute stage and carries them through the MEM and WB stages. It drives the vector register-file write port. It is the producer of the MEM/WB forwarding signals that the execute-stage bypass unit consumes, and it also provides a pending-write scoreboard used by decode for hazard stalls.

## Interface
Parameters:
- DATA_W, 128, vector register width in bits (matches riscv_v_data_t)
- XLEN, 32, scalar integer width (matches riscv_data_t)
- NUM_BYTES, DATA_W/8, per-byte write-enable width (matches riscv_v_rf_wr_en_t)
- ADDR_W, 5, register address width (32 vector registers)
- CNT_W, 16, retire counter width

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous and active-high
- valid_exe  in  1  execute stage holds a valid instruction
- flush_exe  in  1  kill the instruction currently in execute
- stall_mem  in  1  hold the MEM stage
- is_v2i_exe  in  1  instruction writes the scalar RF, not the vector RF
- rd_addr_exe  in  ADDR_W  destination register
- wr_en_exe  in  NUM_BYTES  per-byte vector write enable (mask/vl/vstart already applied)
- result_exe  in  DATA_W  vector result
- int_result_exe  in  XLEN  scalar result for v2i ops
- rf_wr_en_mem  out  NUM_BYTES  MEM-stage byte enables (bypass)
- rf_wr_addr_mem  out  ADDR_W  MEM-stage destination
- rf_wr_data_mem  out  DATA_W  MEM-stage data
- rf_wr_en_wb  out  NUM_BYTES  WB byte enables (RF write port and bypass)
- rf_wr_addr_wb  out  ADDR_W  WB destination
- rf_wr_data_wb  out  DATA_W  WB data
- int_wr_valid_wb  out  1  scalar write-back strobe
- int_wr_data_wb  out  XLEN  scalar write-back data
- busy_vreg  out  2^ADDR_W  bit r set when register r has a pending write in MEM or WB
- retire_cnt  out  CNT_W  count of instructions leaving WB

## Operation
- Stage registers, MEM and WB, each hold: valid, v2i, addr, byte enables, vector data, and int data.
- Capture: the MEM stage loads when stall_mem=0. The loaded valid is valid_exe & ~flush_exe. When the loaded valid is 0, the MEM enables are forced to 0. Addr/data may load don't-care values, but the enables must be 0.
- v2i: the vector enables carried into MEM are forced to 0, and int_result_exe is carried instead.
- Stall: the MEM stage holds all fields. WB loads a bubble (valid=0, all enables 0). The instruction already in WB still completes that cycle.
- Flush with stall: MEM holds. The flush affects only the execute instruction, which is not captured during a stall.
- Advance: when stall_mem=0, WB loads the MEM contents every cycle.
- Output mapping:
  - rf_wr_*_mem are the MEM fields, with enables gated by MEM valid.
  - rf_wr_*_wb are the WB fields, gated likewise.
  - int_wr_valid_wb = WB valid & WB v2i.
  - int_wr_data_wb = WB int data.
- busy_vreg is combinational from the stage registers. A bit is set for a stage's addr when that stage is valid, not v2i, and its enables are nonzero. The MEM and WB contributions are OR'd together.
- Valid instructions with all-zero enables still flow and retire, but set no busy bit.
- retire_cnt increments by 1 on each cycle where WB valid=1. It wraps from 2^CNT_W-1 to 0.
- Register v0 gets no special treatment.

## Timing
- Reset values: all outputs are 0, with busy_vreg=0 and retire_cnt=0. The asynchronous assertion clears both stages immediately, including mid-stall.
- Latency:
  - An instruction sampled at edge N appears on the *_mem outputs after edge N and on the *_wb outputs after edge N+1.
  - The RF write happens at edge N+2, so execute-to-writeback is 2 cycles.
  - The MEM and WB outputs of the same register can be valid simultaneously. The bypass gives MEM priority; this block applies no priority of its own.
- Stall of k cycles: *_mem is stable for k+1 cycles, and *_wb shows bubbles for k cycles.
- No combinational path from any input to any output.

## Test plan
- Single op: valid_exe=1, rd=3, wr_en=16'hFFFF, result=128'hA5..A5.
  - Cycle+1: rf_wr_en_mem=FFFF, addr=3, busy_vreg[3]=1.
  - Cycle+2: rf_wr_en_wb=FFFF with the same data.
  - Cycle+3: busy_vreg=0, retire_cnt=1.
- Back-to-back ops: rd=1 then rd=2, both with wr_en=00FF. After one cycle, MEM addr=2 and WB addr=1 simultaneously, and busy_vreg=0x6.
- Stall/flush:
  - Op rd=4 is in MEM and stall_mem=1 for 2 cycles while flush_exe=1 with a new op. The MEM output holds rd=4 for 3 cycles and WB shows 2 bubbles.
  - After release, rd=4 reaches WB. The flushed op never appears, and retire_cnt increases by 1.
- v2i: is_v2i_exe=1, int_result=32'hDEADBEEF, rd=7.
  - rf_wr_en_mem and rf_wr_en_wb are 0 throughout, and busy_vreg[7]=0.
  - int_wr_valid_wb=1 with data DEADBEEF two cycles after capture.
- Reset mid-flight: assert rst asynchronously while ops occupy MEM and WB. All outputs go to 0 before the next clock edge, and no write is observed after deassertion.
- Counter wrap: preload the count by retiring 65535 ops (or force the count to 16'hFFFF). One more retire gives retire_cnt=0.
